pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the `stg_ena` (hold) and `stg_x` (flush) inputs of the PC register and the IF/ID, ID/EX, EX/MEM (ALU) and MEM/WB latches.
- Detects load-use hazards and taken branches, and sequences multi-cycle EX operations (mul/div) with a timeout.
- Sits beside the datapath; it generates the pipeline control and owns no datapath state.

Parameters:
- REG_W, 5, register-index width.
- MC_MAX, 64, maximum cycles waited for `mc_done` before abort (2..255).
- CNT_W, 32, width of the performance counters.

Ports:
- `stg_clk`  in  1  pipeline clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  REG_W each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  REG_W  destination register of the instruction in EX.
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_save_to_reg`  in  1  EX instruction writes the register file.
- `branch_taken`  in  1  EX resolved a taken branch or jump.
- `mc_start`  in  1  EX holds a multi-cycle op; level, valid in RUN only.
- `mc_done`  in  1  multi-cycle unit result valid this cycle.
- `pc_ena`, `if_id_ena`, `id_ex_ena`, `ex_mem_ena`, `mem_wb_ena`  out  1 each  1 = hold that latch; 0 = load.
- `if_id_x`, `id_ex_x`, `ex_mem_x`  out  1 each  1 = clear that latch to a bubble (dominates ena).
- `mc_err`  out  1  one-cycle pulse on multi-cycle timeout.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  performance counters (see Optional Feature).

Behaviour:
- Outputs are combinational (Mealy) from state plus inputs.
- State, timeout counter and performance counters are registered on `stg_clk`.
- Default output values, unless overridden below: all `*_ena` = 0, all `*_x` = 0, `mc_err` = 0.
- Reset (`reset_n` = 0, asynchronous): state = RUN, `wait_cnt` = 0, counters = 0, outputs at defaults.
- States: RUN, MC_WAIT.
- RUN, evaluated in priority order:
  1. `branch_taken`: `if_id_x` = 1, `id_ex_x` = 1; no stall; `mc_start` and load-use are ignored this cycle. Next state RUN.
  2. `mc_start` && `mc_done` (single-cycle completion): no action; stay in RUN.
  3. `mc_start`: `pc_ena` = `if_id_ena` = `id_ex_ena` = 1, `ex_mem_x` = 1. Next state MC_WAIT, `wait_cnt` = 1.
  4. Load-use, i.e. `ex_is_load` && `ex_save_to_reg` && `ex_rd` != 0 && ((`id_use_rs1` && `id_rs1` == `ex_rd`) || (`id_use_rs2` && `id_rs2` == `ex_rd`)): `pc_ena` = `if_id_ena` = 1, `id_ex_x` = 1. Exactly one bubble per hazard, because the load advances on the next edge.
- MC_WAIT:
  - `mc_done` = 1: all defaults; EX/MEM loads the result; next state RUN, `wait_cnt` = 0. `mc_done` wins even when `wait_cnt` == MC_MAX.
  - Otherwise, `wait_cnt` < MC_MAX: same outputs as RUN case 3; `wait_cnt` increments.
  - Otherwise, `wait_cnt` == MC_MAX: `mc_err` = 1, `ex_mem_x` = 1, `pc_ena` = `if_id_ena` = 0, `id_ex_x` = 1 (drop the op); next state RUN.
  - `branch_taken` and load-use inputs are ignored in MC_WAIT.
- `mem_wb_ena` is always 0; this port is reserved for future memory stalls.
- Register x0 never creates a hazard.
- Reset asserted while in MC_WAIT returns immediately to RUN with default outputs.

Optional Feature:
- Macro `PIPE_PERF_EN`.
- Defined:
  - `stall_cnt` += 1 on each clock where `pc_ena` = 1.
  - `flush_cnt` += 1 on each clock where `if_id_x` || `id_ex_x` || `ex_mem_x`.
  - Both counters saturate at all-ones and clear on reset.
- Not defined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
- Load-use: `ex_is_load` = 1, `ex_save_to_reg` = 1, `ex_rd` = 5, `id_rs2` = 5, `id_use_rs2` = 1 -> `pc_ena` = `if_id_ena` = `id_ex_x` = 1 for exactly 1 cycle. Same stimulus with `ex_rd` = 0 -> no stall.
- Branch: `branch_taken` = 1 together with a load-use match -> `if_id_x` = `id_ex_x` = 1, `pc_ena` = 0, no stall.
- Multi-cycle: `mc_start` = 1, `mc_done` after 4 cycles -> holds asserted for 4 cycles with `ex_mem_x` = 1, then one cycle of all zeros, state back to RUN.
- Timeout: MC_MAX = 8, `mc_start` and `mc_done` never asserted -> 8 stall cycles, then `mc_err` pulse and `id_ex_x` = `ex_mem_x` = 1, then RUN. `mc_done` arriving on cycle 8 -> no `mc_err`.
- Reset: deassert `reset_n` in the 3rd cycle of MC_WAIT -> outputs at defaults immediately, RUN after release, counters = 0.
- `PIPE_PERF_EN` defined: 2 load-use stalls + 1 branch -> `stall_cnt` = 2, `flush_cnt` = 3. Not defined: both read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a 5-stage pipeline.
//   Ports: stg_clk/reset_n (async active-low); ID source regs and use flags;
//   EX dest/load/writeback flags; branch_taken; mc_start/mc_done handshake;
//   *_ena hold outputs (1 = hold), *_x flush outputs (1 = bubble);
//   mc_err timeout pulse; stall_cnt/flush_cnt performance counters.
//   Define PIPE_PERF_EN to build the counters; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int REG_W  = 5,
  parameter int MC_MAX = 64,
  parameter int CNT_W  = 32
) (
  input  logic             stg_clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_save_to_reg,
  input  logic             branch_taken,
  input  logic             mc_start,
  input  logic             mc_done,
  output logic             pc_ena,
  output logic             if_id_ena,
  output logic             id_ex_ena,
  output logic             ex_mem_ena,
  output logic             mem_wb_ena,
  output logic             if_id_x,
  output logic             id_ex_x,
  output logic             ex_mem_x,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, MC_WAIT} state_t;
  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       load_use;
  assign load_use = ex_is_load && ex_save_to_reg && (ex_rd != '0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign mem_wb_ena = 1'b0;
  assign ex_mem_ena = 1'b0;
  // Outputs are forced to defaults while reset is held so the pipeline
  // cannot see a stall even if EX inputs are still active.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pc_ena     = 1'b0;
    if_id_ena  = 1'b0;
    id_ex_ena  = 1'b0;
    if_id_x    = 1'b0;
    id_ex_x    = 1'b0;
    ex_mem_x   = 1'b0;
    mc_err     = 1'b0;
    if (reset_n) begin
      if (state_q == RUN) begin
        if (branch_taken) begin
          if_id_x = 1'b1;
          id_ex_x = 1'b1;
        end else if (mc_start && !mc_done) begin
          pc_ena     = 1'b1;
          if_id_ena  = 1'b1;
          id_ex_ena  = 1'b1;
          ex_mem_x   = 1'b1;
          state_d    = MC_WAIT;
          wait_cnt_d = 8'd1;
        end else if (!mc_start && load_use) begin
          pc_ena    = 1'b1;
          if_id_ena = 1'b1;
          id_ex_x   = 1'b1;
        end
      end else begin
        if (mc_done) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < 8'(MC_MAX)) begin
          pc_ena     = 1'b1;
          if_id_ena  = 1'b1;
          id_ex_ena  = 1'b1;
          ex_mem_x   = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          mc_err     = 1'b1;
          ex_mem_x   = 1'b1;
          id_ex_x    = 1'b1;
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end
      end
    end
  end
  always_ff @(posedge stg_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge stg_clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_ena && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((if_id_x || id_ex_x || ex_mem_x) && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  localparam int REG_W  = 5;
  localparam int MC_MAX = 8;
  localparam int CNT_W  = 32;
  // outs = {pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena, if_id_x, id_ex_x, ex_mem_x, mc_err}
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] HOLD = 9'b111000010;
  localparam logic [8:0] LU   = 9'b110000100;
  localparam logic [8:0] BR   = 9'b000001100;
  localparam logic [8:0] TOUT = 9'b000000111;
  logic             stg_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic             ex_is_load = 1'b0, ex_save_to_reg = 1'b0;
  logic             branch_taken = 1'b0, mc_start = 1'b0, mc_done = 1'b0;
  logic             pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena;
  logic             if_id_x, id_ex_x, ex_mem_x, mc_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0]       outs;
  int errors = 0;
  int checks = 0;
  always #5 stg_clk = ~stg_clk;
  assign outs = {pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena, if_id_x, id_ex_x, ex_mem_x, mc_err};
  pipe_hazard_ctrl #(.REG_W(REG_W), .MC_MAX(MC_MAX), .CNT_W(CNT_W)) dut (
    .stg_clk(stg_clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_save_to_reg(ex_save_to_reg),
    .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
    .pc_ena(pc_ena), .if_id_ena(if_id_ena), .id_ex_ena(id_ex_ena), .ex_mem_ena(ex_mem_ena),
    .mem_wb_ena(mem_wb_ena), .if_id_x(if_id_x), .id_ex_x(id_ex_x), .ex_mem_x(ex_mem_x),
    .mc_err(mc_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  // Drive one cycle's inputs at the falling edge; lu selects a load to x5 matched by rs2.
  task automatic set_in(input logic br, input logic mcs, input logic mcd, input logic lu);
    @(negedge stg_clk);
    branch_taken   = br;
    mc_start       = mcs;
    mc_done        = mcd;
    ex_is_load     = lu;
    ex_save_to_reg = lu;
    ex_rd          = lu ? 5'd5 : 5'd0;
    id_rs1         = 5'd3;
    id_rs2         = 5'd5;
    id_use_rs1     = 1'b1;
    id_use_rs2     = 1'b1;
    #1;
  endtask
  task automatic test_reset;
    branch_taken = 1'b1;
    mc_start     = 1'b1;
    #2;
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, NONE); end
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    set_in(0, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL reset_release: got %b want %b", outs, NONE); end
  endtask
  task automatic test_load_use;
    set_in(0, 0, 0, 1);
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL lu_rs2: got %b want %b", outs, LU); end
    set_in(0, 0, 0, 0);
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL lu_one_bubble: got %b want %b", outs, NONE); end
    set_in(0, 0, 0, 1);
    ex_rd = 5'd0; id_rs2 = 5'd0; id_rs1 = 5'd0;
    #1;
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL lu_x0: got %b want %b", outs, NONE); end
    set_in(0, 0, 0, 1);
    id_rs2 = 5'd7; id_rs1 = 5'd5;
    #1;
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL lu_rs1: got %b want %b", outs, LU); end
    set_in(0, 0, 0, 1);
    id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL lu_unused_rs2: got %b want %b", outs, NONE); end
    set_in(0, 0, 0, 1);
    ex_save_to_reg = 1'b0;
    #1;
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL lu_no_write: got %b want %b", outs, NONE); end
  endtask
  task automatic test_branch;
    set_in(1, 0, 0, 1);
    checks++;
    if (outs !== BR) begin errors++; $display("FAIL branch_over_lu: got %b want %b", outs, BR); end
    set_in(1, 1, 0, 0);
    checks++;
    if (outs !== BR) begin errors++; $display("FAIL branch_over_mc: got %b want %b", outs, BR); end
    set_in(0, 0, 0, 0);
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL branch_after: got %b want %b", outs, NONE); end
  endtask
  task automatic test_multicycle;
    logic [8:0] exp [0:6];
    logic [3:0] stim [0:6];
    exp  = '{HOLD, HOLD, HOLD, HOLD, NONE, NONE, LU};
    stim = '{4'b0100, 4'b1100, 4'b0101, 4'b0100, 4'b0110, 4'b0000, 4'b0001};
    for (int i = 0; i < 7; i++) begin
      set_in(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if (outs !== exp[i]) begin errors++; $display("FAIL mc_step%0d: got %b want %b", i, outs, exp[i]); end
    end
  endtask
  task automatic test_single_cycle;
    set_in(0, 1, 1, 1);
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL mc_single: got %b want %b", outs, NONE); end
    set_in(0, 0, 0, 1);
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL mc_single_run: got %b want %b", outs, LU); end
  endtask
  task automatic test_timeout;
    for (int i = 0; i < MC_MAX; i++) begin
      set_in(0, i == 0, 0, 0);
      checks++;
      if (outs !== HOLD) begin errors++; $display("FAIL to_hold%0d: got %b want %b", i, outs, HOLD); end
    end
    set_in(0, 0, 0, 0);
    checks++;
    if (outs !== TOUT) begin errors++; $display("FAIL to_err: got %b want %b", outs, TOUT); end
    set_in(0, 0, 0, 1);
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL to_back_run: got %b want %b", outs, LU); end
  endtask
  task automatic test_done_at_max;
    for (int i = 0; i < MC_MAX; i++) begin
      set_in(0, i == 0, 0, 0);
      checks++;
      if (outs !== HOLD) begin errors++; $display("FAIL dm_hold%0d: got %b want %b", i, outs, HOLD); end
    end
    set_in(0, 0, 1, 0);
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL dm_done_wins: got %b want %b", outs, NONE); end
    set_in(0, 0, 0, 1);
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL dm_back_run: got %b want %b", outs, LU); end
  endtask
  task automatic test_reset_mc_wait;
    set_in(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) set_in(0, 0, 0, 0);
    checks++;
    if (outs !== HOLD) begin errors++; $display("FAIL rw_in_wait: got %b want %b", outs, HOLD); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs !== NONE) begin errors++; $display("FAIL rw_async: got %b want %b", outs, NONE); end
    set_in(0, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL rw_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    set_in(0, 0, 0, 1);
    checks++;
    if (outs !== LU) begin errors++; $display("FAIL rw_run: got %b want %b", outs, LU); end
  endtask
  task automatic test_perf;
    logic [CNT_W-1:0] exp_s, exp_f;
`ifdef PIPE_PERF_EN
    exp_s = 2; exp_f = 3;
`else
    exp_s = 0; exp_f = 0;
`endif
    set_in(0, 0, 0, 0);
    reset_n = 1'b0;
    set_in(0, 0, 0, 0);
    reset_n = 1'b1;
    set_in(0, 0, 0, 1);
    set_in(0, 0, 0, 0);
    set_in(0, 0, 0, 1);
    set_in(0, 0, 0, 0);
    set_in(1, 0, 0, 0);
    set_in(0, 0, 0, 0);
    checks++;
    if (stall_cnt !== exp_s) begin errors++; $display("FAIL perf_stall: got %0d want %0d", stall_cnt, exp_s); end
    checks++;
    if (flush_cnt !== exp_f) begin errors++; $display("FAIL perf_flush: got %0d want %0d", flush_cnt, exp_f); end
  endtask
  initial begin
    test_reset;
    test_load_use;
    test_branch;
    test_multicycle;
    test_single_cycle;
    test_timeout;
    test_done_at_max;
    test_reset_mc_wait;
    test_perf;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
